// File: rtl/req_encoder_32bit_pkg.sv
// Shared widths and FSM state encoding for the 32-bit request encoder.
package req_encoder_32bit_pkg;
   localparam int REQ_W = 32;
   localparam int IDX_W = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;
endpackage

// File: rtl/req_encoder_32bit_if.sv
// Request/offer bus of the 32-bit request encoder; slave side is the encoder.
interface req_encoder_32bit_if
   import req_encoder_32bit_pkg::*;
;
   logic [REQ_W-1:0] set_vec;
   logic             en;
   logic             clr;
   logic             ready_in;
   logic             valid_out;
   logic [IDX_W-1:0] idx_out;
   logic [REQ_W-1:0] pending;
   logic [IDX_W:0]   pend_cnt;

   modport master (
      output set_vec, en, clr, ready_in,
      input  valid_out, idx_out, pending, pend_cnt
   );

   modport slave (
      input  set_vec, en, clr, ready_in,
      output valid_out, idx_out, pending, pend_cnt
   );
endinterface

// File: rtl/pri_find_32bit.sv
// Combinational priority finder: first set bit of vec searching upward from start, wrapping 31->0.
module pri_find_32bit
   import req_encoder_32bit_pkg::*;
(
   input  logic [REQ_W-1:0] vec,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);
   logic [IDX_W-1:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = 0; i < REQ_W; i++) begin
         pos = start + IDX_W'(i);
         if (!found && vec[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end
endmodule

// File: rtl/req_encoder_32bit.sv
// Pending-request encoder offering one index per cycle over a valid/ready handshake.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection instead of lowest-index.
module req_encoder_32bit
   import req_encoder_32bit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   req_encoder_32bit_if.slave  bus
);
   state_t           state_q, state_d;
   logic [REQ_W-1:0] pending_q, pending_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [REQ_W-1:0] acc_mask, search_vec;
   logic [IDX_W-1:0] start;
   logic [IDX_W:0]   cnt;
   logic             hs, found;
   logic [IDX_W-1:0] found_idx;

   // A flush cancels the handshake, so nothing is consumed on a clr cycle.
   assign hs = valid_q & bus.ready_in & ~bus.clr;

   always_comb begin
      acc_mask = '0;
      if (hs) acc_mask[idx_q] = 1'b1;
   end

   // The finder only ever sees registered requests; same-cycle set_vec waits a cycle.
   assign search_vec = pending_q & ~acc_mask;

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   assign rr_ptr_d = hs ? idx_q + IDX_W'(1) : rr_ptr_q;
   assign start    = rr_ptr_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`else
   assign start = '0;
`endif

   pri_find_32bit u_find (
      .vec   (search_vec),
      .start (start),
      .found (found),
      .idx   (found_idx)
   );

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      idx_d     = idx_q;
      pending_d = search_vec | (bus.en ? bus.set_vec : '0);
      if (bus.clr) begin
         pending_d = '0;
         valid_d   = 1'b0;
         state_d   = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  idx_d   = found_idx;
                  valid_d = 1'b1;
                  state_d = OFFER;
               end
            end
            OFFER: begin
               if (hs) begin
                  if (found) begin
                     idx_d = found_idx;
                  end else begin
                     valid_d = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
      end
   end

   always_comb begin
      cnt = '0;
      for (int i = 0; i < REQ_W; i++) cnt = cnt + {{IDX_W{1'b0}}, pending_q[i]};
   end

   assign bus.valid_out = valid_q;
   assign bus.idx_out   = idx_q;
   assign bus.pending   = pending_q;
   assign bus.pend_cnt  = cnt;
endmodule

// File: tb/tb_req_encoder_32bit.sv
// Randomized and directed bench for req_encoder_32bit against a behavioural reference model.
module tb_req_encoder_32bit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   req_encoder_32bit_if bus ();

   req_encoder_32bit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference state: the set of pending requests and the current offer.
   logic [31:0] m_pend;
   logic        m_valid;
   int          m_idx;
   int          m_last;   // last accepted index, -1 when none since reset

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int pick(input logic [31:0] v, input int last);
      int first;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
      first = (last + 1) % 32;
`else
      first = 0;
      if (last > 99) first = 1;
`endif
      for (int k = 0; k < 32; k++)
         if (v[(first + k) % 32]) return (first + k) % 32;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_last  = -1;
   endtask

   task automatic check_all();
      chk("valid_out", {31'd0, bus.valid_out}, {31'd0, m_valid});
      if (m_valid) chk("idx_out", {27'd0, bus.idx_out}, m_idx);
      chk("pending", bus.pending, m_pend);
      chk("pend_cnt", {26'd0, bus.pend_cnt}, $countones(m_pend));
   endtask

   task automatic step(input logic [31:0] sv, input logic e, input logic c, input logic r);
      logic [31:0] rem, nxt;
      logic        take;
      int          s;
      bus.set_vec  = sv;
      bus.en       = e;
      bus.clr      = c;
      bus.ready_in = r;
      take = m_valid && r && !c;
      rem  = m_pend;
      if (take) begin
         rem[m_idx] = 1'b0;
         m_last = m_idx;
      end
      nxt = rem | (e ? sv : 32'd0);
      if (c) begin
         nxt     = '0;
         m_valid = 1'b0;
      end else if (!m_valid || take) begin
         s = pick(rem, m_last < 0 ? 31 : m_last);
         if (s >= 0) begin
            m_idx   = s;
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      m_pend = nxt;
      check_all();
   endtask

   initial begin
      rst          = 1'b1;
      bus.set_vec  = '0;
      bus.en       = 1'b0;
      bus.clr      = 1'b0;
      bus.ready_in = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("rst_idx", {27'd0, bus.idx_out}, 32'd0);
      chk("rst_pending", bus.pending, 32'd0);
      chk("rst_cnt", {26'd0, bus.pend_cnt}, 32'd0);
      #11 rst = 1'b0;

      // Basic single request.
      step(32'h0000_0004, 1, 0, 0);
      chk("basic_not_yet", {31'd0, bus.valid_out}, 32'd0);
      step(32'h0, 0, 0, 0);
      chk("basic_idx", {27'd0, bus.idx_out}, 32'd2);
      chk("basic_cnt", {26'd0, bus.pend_cnt}, 32'd1);
      step(32'h0, 0, 0, 1);
      chk("basic_drop", {31'd0, bus.valid_out}, 32'd0);
      chk("basic_empty", bus.pending, 32'd0);

      // Burst, ready held high.
      step(32'h8000_0011, 1, 0, 1);
      step(32'h0, 0, 0, 1);
`ifndef REQ_ENCODER_ROUND_ROBIN_EN
      chk("burst_0", {27'd0, bus.idx_out}, 32'd0);
`endif
      step(32'h0, 0, 0, 1);
`ifndef REQ_ENCODER_ROUND_ROBIN_EN
      chk("burst_4", {27'd0, bus.idx_out}, 32'd4);
`endif
      step(32'h0, 0, 0, 1);
`ifndef REQ_ENCODER_ROUND_ROBIN_EN
      chk("burst_31", {27'd0, bus.idx_out}, 32'd31);
`endif
      step(32'h0, 0, 0, 1);

      // Offer stability under a new request.
      step(32'h0000_0020, 1, 0, 0);
      step(32'h0, 0, 0, 0);
      step(32'h0000_0002, 1, 0, 0);
      chk("stable_5", {27'd0, bus.idx_out}, 32'd5);
      step(32'h0, 0, 0, 0);
      chk("stable_5b", {27'd0, bus.idx_out}, 32'd5);
      step(32'h0, 0, 0, 1);
      chk("after_5", {27'd0, bus.idx_out}, 32'd1);
      step(32'h0, 0, 0, 1);

      // Set and accept colliding on the same bit.
      step(32'h0000_0008, 1, 0, 0);
      step(32'h0, 0, 0, 0);
      chk("coll_offer", {27'd0, bus.idx_out}, 32'd3);
      step(32'h0000_0008, 1, 0, 1);
      chk("coll_keep", bus.pending, 32'h0000_0008);
      chk("coll_cnt", {26'd0, bus.pend_cnt}, 32'd1);
      step(32'h0, 0, 0, 0);
      chk("coll_reoffer", {27'd0, bus.idx_out}, 32'd3);
      step(32'h0, 0, 0, 1);
      step(32'h0, 0, 0, 0);

      // Flush of a full register.
      step(32'hFFFF_FFFF, 1, 0, 0);
      chk("full_cnt", {26'd0, bus.pend_cnt}, 32'd32);
      step(32'h0, 0, 0, 0);
      step(32'hFFFF_FFFF, 1, 1, 1);
      chk("flush_pend", bus.pending, 32'd0);
      chk("flush_valid", {31'd0, bus.valid_out}, 32'd0);

      // Asynchronous reset during an offer.
      step(32'h0000_0020, 1, 0, 0);
      step(32'h0, 0, 0, 0);
      chk("pre_rst_valid", {31'd0, bus.valid_out}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", {31'd0, bus.valid_out}, 32'd0);
      chk("async_pend", bus.pending, 32'd0);
      chk("async_cnt", {26'd0, bus.pend_cnt}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 2000; n++) begin
         logic [31:0] sv;
         sv = ($urandom % 8 == 0) ? $urandom : ($urandom & $urandom & $urandom);
         step(sv, ($urandom % 3) == 0, ($urandom % 50) == 0, $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/req_encoder_32bit.md
REQ_ENCODER_32BIT -- requirements
Module: req_encoder_32bit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all state SHALL update on posedge clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 set_vec  input  32  multi-hot request bits, ORed into the pending register when en=1.
REQ-005 en  input  1  sample enable for set_vec.
REQ-006 clr  input  1  synchronous flush of all pending requests and any current offer.
REQ-007 ready_in  input  1  consumer accepts idx_out this cycle.
REQ-008 valid_out  output  1  idx_out holds a valid pending index.
REQ-009 idx_out  output  5  binary index of the offered request.
REQ-010 pending  output  32  pending register contents.
REQ-011 pend_cnt  output  6  population count of pending, range 0..32.

Function
REQ-012 The pending register SHALL update each edge as follows:
- start from pending;
- clear bit idx_out if the handshake (valid_out & ready_in) completes;
- then OR in set_vec if en=1.
REQ-013 If set and clear hit the same bit in one cycle, set SHALL win and the bit SHALL stay pending.
REQ-014 clr=1 SHALL take priority over en and the handshake. Next edge: pending=0, set_vec discarded, valid_out=0, state=IDLE.
REQ-015 The FSM SHALL have two states, IDLE and OFFER.
REQ-016 IDLE: if pending!=0, load idx_out with the selected index, set valid_out=1 and go to OFFER; otherwise remain in IDLE.
REQ-017 OFFER, while ready_in=0: idx_out and valid_out SHALL stay stable, even if new higher-priority requests arrive.
REQ-018 OFFER, on handshake: if (pending & ~onehot(idx_out)) != 0, load the next selected index from that vector and stay in OFFER (back-to-back, 1 index/cycle); otherwise go to IDLE with valid_out=0.
REQ-019 Same-cycle set_vec SHALL NOT take part in the REQ-018 next selection; it becomes eligible from the following cycle.
REQ-020 Latency: set_vec sampled at edge N into an empty, idle block SHALL give valid_out=1 after edge N+1.
REQ-021 Selection (default): the lowest-index set bit.
REQ-022 pend_cnt SHALL be combinational from the pending register.
REQ-023 Each index SHALL be emitted exactly once per set/accept cycle; an accepted index never reappears unless set again.

Reset
REQ-024 On rst=1, without waiting for clk, the block SHALL reset to:
- pending=0, pend_cnt=0
- valid_out=0, idx_out=0
- state=IDLE
- round-robin pointer=0.
REQ-025 Reset asserted mid-offer SHALL drop the offer without a handshake.

Configuration
REQ-026 Macro REQ_ENCODER_ROUND_ROBIN_EN, when defined, SHALL make selection round-robin:
- the search starts at (last accepted index + 1) mod 32 and wraps 31->0;
- the pointer updates only on a handshake.
REQ-027 Without REQ_ENCODER_ROUND_ROBIN_EN, selection SHALL be fixed lowest-index and no pointer register SHALL exist.

Structure
REQ-028 A shared package SHALL hold:
- REQ_W=32 and IDX_W=5;
- the IDLE/OFFER state encoding.
REQ-029 A combinational sub-module pri_find_32bit SHALL be used for selection:
- inputs: vec[31:0] and start[4:0];
- outputs: found and idx[4:0];
- start is tied to 0 when round-robin is compiled out.

Verification
REQ-030 Reset/basic: release rst; en=1, set_vec=32'h0000_0004 for one cycle -> valid_out=1 with idx_out=2 two edges later; pend_cnt=1; ready_in=1 -> valid_out=0 next cycle, pending=0.
REQ-031 Burst: set_vec=32'h8000_0011, ready_in held 1 -> idx_out 0,4,31 on consecutive cycles (default build); with REQ_ENCODER_ROUND_ROBIN_EN after prior accept of 4, order 31,0,4.
REQ-032 Stability: offering idx 5 with ready_in=0, set bit 1 -> idx_out stays 5 until accepted, then 1.
REQ-033 Collision: offering 3, ready_in=1 and en=1 with set_vec bit 3 in the same cycle -> bit 3 remains pending and is re-offered later; pend_cnt is unchanged.
REQ-034 Flush: pending=32'hFFFF_FFFF (pend_cnt=32), clr=1 with en=1 -> next cycle pending=0, valid_out=0, pend_cnt=0.
REQ-035 Async reset: assert rst between edges during OFFER -> valid_out=0 immediately, before the next edge.
